load_writeback_unit: RTL and testbench
======================================

Name: load_writeback_unit

Overview:
Load-data return stage between the Avalon data-memory port and the register-file write port of the multicycle MIPS core. It captures memory read data under waitrequest and stalls the controller until data arrives. It performs byte-lane extraction, sign/zero extension and LWL/LWR merging, then issues a one-cycle register write of the result in WRITE_BACK. ALU, link and non-load writebacks bypass this block.

Parameters:
DATA_W, 32, data word width (fixed at 32; not a scaling parameter)
STATE_MEM, 3'b011, encoding of MEMORY_ACCESS on state
STATE_WB, 3'b100, encoding of WRITE_BACK on state

Ports:
clk  in  1  core clock, all flops on rising edge
reset  in  1  asynchronous, active-high; clears FSM and all outputs
state  in  3  controller state (FETCH_INSTR=000 .. WRITE_BACK=100)
instr  in  32  current instruction; opcode=[31:26], rt=[20:16]
eff_addr_lo  in  2  low bits of load effective address (byte offset k)
mem_read  in  1  controller read strobe to data memory
waitrequest  in  1  Avalon waitrequest from data memory
readdata  in  32  Avalon read data; byte k = readdata[8k+7:8k] (little-endian)
rt_old  in  32  current contents of register rt (for LWL/LWR merge)
stall  out  1  hold controller in MEMORY_ACCESS
wb_valid  out  1  register write enable, one-cycle pulse
wb_reg  out  5  destination register (= rt)
wb_data  out  32  value to write
misaligned  out  1  sticky-until-next-load alignment fault flag

Behaviour:
- Reset (async): FSM=IDLE; stall=0, wb_valid=0, wb_reg=0, wb_data=0, misaligned=0; internal latches cleared.
- Load opcodes: LB 100000, LH 100001, LWL 100010, LW 100011, LBU 100100, LHU 100101, LWR 100110. Anything else is "non-load": block stays IDLE, wb_valid=0.
- Start condition: state==STATE_MEM & mem_read & load opcode while IDLE.
- FSM IDLE: on start latch opcode, rt, k, rt_old; clear misaligned.
  - If misaligned (LH/LHU with k[0]=1, LW with k!=0): set misaligned=1, stay IDLE, no bus wait, no write.
  - Else if waitrequest=0 same cycle: capture readdata, go HOLD (zero-wait path, stall never asserted).
  - Else go WAIT_MEM.
- stall is combinational: 1 when (IDLE & start & aligned & waitrequest) or (WAIT_MEM & waitrequest); 0 otherwise.
- WAIT_MEM: on waitrequest=0 capture readdata, go HOLD. If state leaves STATE_MEM while here: abort to IDLE, no write.
- HOLD: when state==STATE_WB, drive wb_valid=1 for exactly that cycle with wb_reg/wb_data, go IDLE. If state goes to anything other than STATE_MEM/STATE_WB: abort to IDLE, no write.
- wb_reg/wb_data registered; hold last value after wb_valid drops. wb_reg=0 still pulses wb_valid; $zero protection is the register file's job.
- Data formation (D = captured word, k = latched offset, R = latched rt_old):
  - LB/LBU: byte k, sign/zero extend to 32.
  - LH/LHU: half k[1] (bytes 2k[1],2k[1]+1), sign/zero extend.
  - LW: D.
  - LWL: (D << 8*(3-k)) | (R & ((1<<8*(3-k))-1)); k=3 gives D.
  - LWR: (D >> 8*k) | (R & ~(32'hFFFFFFFF >> 8*k)); k=0 gives D.
- Latency: wb_valid asserted in the first WRITE_BACK cycle after data capture; no combinational path from readdata to wb_data.
- New start while HOLD is impossible by controller order. If one is seen, the new load takes precedence and the old result is dropped.
- Reset asserted in any state: immediate return to IDLE, pending write discarded, stall drops asynchronously.

Test Plan:
- LB, k=3, readdata=0x80FF1234, 0 waits -> stall never 1; WRITE_BACK gives wb_valid=1, wb_data=0xFFFFFF80, wb_reg=rt.
- LHU, k=2, readdata=0x80FF1234 -> wb_data=0x000080FF; LH same inputs -> 0xFFFF80FF.
- LWL, k=1, rt_old=0xAABBCCDD, readdata=0x11223344 -> wb_data=0x3344CCDD. LWR, k=2, same inputs -> 0xAABB1122.
- LW, waitrequest high 3 cycles then low with 0xDEADBEEF -> stall=1 for exactly 3 cycles; single wb_valid pulse with 0xDEADBEEF.
- LW, k=2 -> misaligned=1, stall=0, no wb_valid. Next aligned load clears misaligned.
- Reset pulsed during WAIT_MEM, then state stepped to WRITE_BACK -> all outputs 0, no wb_valid. An ADDU (opcode 0) in WRITE_BACK also gives no wb_valid.

Source files
------------

// File: rtl/load_writeback_unit_if.sv
// Interface between the multicycle controller/data memory and the load
// writeback unit.
//
// master : controller + Avalon data-memory side (drives state, instruction,
//          address offset, read strobe, waitrequest, readdata, rt_old;
//          consumes stall and the register write port)
// slave  : load_writeback_unit
//
// Signals:
//   state        controller state (FETCH_INSTR=000 .. WRITE_BACK=100)
//   instr        current instruction (opcode=[31:26], rt=[20:16])
//   eff_addr_lo  byte offset of the load effective address
//   mem_read     controller read strobe
//   waitrequest  Avalon waitrequest
//   readdata     Avalon read data, little-endian byte lanes
//   rt_old       current contents of register rt
//   stall        hold controller in MEMORY_ACCESS
//   wb_valid     one-cycle register write enable
//   wb_reg       destination register
//   wb_data      value to write
//   misaligned   sticky alignment fault flag
interface load_writeback_unit_if;
  logic [2:0]  state;
  logic [31:0] instr;
  logic [1:0]  eff_addr_lo;
  logic        mem_read;
  logic        waitrequest;
  logic [31:0] readdata;
  logic [31:0] rt_old;
  logic        stall;
  logic        wb_valid;
  logic [4:0]  wb_reg;
  logic [31:0] wb_data;
  logic        misaligned;

  modport master (
    output state, instr, eff_addr_lo, mem_read, waitrequest, readdata, rt_old,
    input  stall, wb_valid, wb_reg, wb_data, misaligned
  );

  modport slave (
    input  state, instr, eff_addr_lo, mem_read, waitrequest, readdata, rt_old,
    output stall, wb_valid, wb_reg, wb_data, misaligned
  );
endinterface

// File: rtl/load_writeback_unit.sv
// Load-data return stage of the multicycle MIPS core.
//
// Captures Avalon read data (stalling the controller while waitrequest is
// high), extracts the addressed byte/half, applies sign/zero extension or the
// LWL/LWR merge with the old rt value, and issues a one-cycle register write
// during WRITE_BACK. Non-load writebacks never pass through this block.
//
// Ports:
//   clk    core clock, rising edge
//   reset  asynchronous active-high reset
//   bus    load_writeback_unit_if.slave (see interface file for signal list)
module load_writeback_unit #(
  parameter int          DATA_W    = 32,
  parameter logic [2:0]  STATE_MEM = 3'b011,
  parameter logic [2:0]  STATE_WB  = 3'b100
) (
  input  logic                  clk,
  input  logic                  reset,
  load_writeback_unit_if.slave  bus
);

  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LWL = 6'b100010;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_LHU = 6'b100101;
  localparam logic [5:0] OP_LWR = 6'b100110;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_MEM = 2'd1,
    HOLD     = 2'd2
  } fsm_t;

  fsm_t fsm_reg, fsm_next;

  // Latched load context
  logic [5:0]        op_reg;
  logic [4:0]        rt_reg;
  logic [1:0]        k_reg;
  logic [DATA_W-1:0] rt_old_reg;

  // Output registers
  logic [4:0]        wb_reg_reg;
  logic [DATA_W-1:0] wb_data_reg;
  logic              misaligned_reg;

  // Decode of the live instruction
  logic [5:0] opcode;
  logic [4:0] rt;
  logic       is_load;
  logic       misalign;
  logic       start;

  // Control strobes from the next-state logic
  logic latch;
  logic capture;
  logic set_mis;
  logic wb_fire;
  logic stall_int;

  // Operands used to form the result at capture time
  logic [5:0]        fmt_op;
  logic [1:0]        fmt_k;
  logic [DATA_W-1:0] fmt_r;
  logic [4:0]        fmt_rt;
  logic [DATA_W-1:0] fmt_data;

  // Instruction fields this block does not look at
  logic unused_instr_bits;
  assign unused_instr_bits = ^{bus.instr[25:21], bus.instr[15:0]};

  assign opcode = bus.instr[31:26];
  assign rt     = bus.instr[20:16];

  function automatic logic op_is_load(input logic [5:0] op);
    case (op)
      OP_LB, OP_LH, OP_LWL, OP_LW, OP_LBU, OP_LHU, OP_LWR: op_is_load = 1'b1;
      default:                                            op_is_load = 1'b0;
    endcase
  endfunction

  // Halfword loads need an even offset, full-word loads need offset 0.
  // Byte loads and the unaligned LWL/LWR are legal at any offset.
  function automatic logic op_misaligned(input logic [5:0] op, input logic [1:0] k);
    case (op)
      OP_LH, OP_LHU: op_misaligned = k[0];
      OP_LW:         op_misaligned = (k != 2'd0);
      default:       op_misaligned = 1'b0;
    endcase
  endfunction

  // Byte-lane extraction, extension and LWL/LWR merge.
  function automatic logic [DATA_W-1:0] form_result(
    input logic [5:0]        op,
    input logic [1:0]        k,
    input logic [DATA_W-1:0] r,
    input logic [DATA_W-1:0] d
  );
    logic [4:0]        sh_r;
    logic [4:0]        sh_l;
    logic [DATA_W-1:0] d_shr;
    logic [7:0]        b;
    logic [15:0]       h;
    sh_r  = {k, 3'b000};
    // 8*(3-k): for a 2-bit k, 3-k is simply ~k
    sh_l  = {~k, 3'b000};
    d_shr = d >> sh_r;
    b     = d_shr[7:0];
    h     = k[1] ? d[31:16] : d[15:0];
    case (op)
      OP_LB:   form_result = {{24{b[7]}}, b};
      OP_LBU:  form_result = {24'd0, b};
      OP_LH:   form_result = {{16{h[15]}}, h};
      OP_LHU:  form_result = {16'd0, h};
      OP_LWL:  form_result = (d << sh_l) | (r & ((32'd1 << sh_l) - 32'd1));
      OP_LWR:  form_result = d_shr | (r & ~(32'hFFFF_FFFF >> sh_r));
      default: form_result = d;
    endcase
  endfunction

  assign is_load  = op_is_load(opcode);
  assign misalign = op_misaligned(opcode, bus.eff_addr_lo);

  // A start is accepted in IDLE, and also in HOLD where a new load replaces
  // an unwritten result. Never in WAIT_MEM: mem_read stays high there.
  assign start = (bus.state == STATE_MEM) && bus.mem_read && is_load &&
                 (fsm_reg != WAIT_MEM);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fsm_reg <= IDLE;
    end else begin
      fsm_reg <= fsm_next;
    end
  end

  always_comb begin
    fsm_next  = fsm_reg;
    latch     = 1'b0;
    capture   = 1'b0;
    set_mis   = 1'b0;
    wb_fire   = 1'b0;
    stall_int = 1'b0;
    case (fsm_reg)
      IDLE, HOLD: begin
        if (start) begin
          latch = 1'b1;
          if (misalign) begin
            set_mis  = 1'b1;
            fsm_next = IDLE;
          end else if (!bus.waitrequest) begin
            capture  = 1'b1;
            fsm_next = HOLD;
          end else begin
            stall_int = 1'b1;
            fsm_next  = WAIT_MEM;
          end
        end else if (fsm_reg == HOLD) begin
          if (bus.state == STATE_WB) begin
            wb_fire  = 1'b1;
            fsm_next = IDLE;
          end else if (bus.state != STATE_MEM) begin
            fsm_next = IDLE;
          end
        end
      end
      WAIT_MEM: begin
        stall_int = bus.waitrequest;
        // Controller leaving MEMORY_ACCESS cancels the load even if data
        // happens to arrive in the same cycle.
        if (bus.state != STATE_MEM) begin
          fsm_next = IDLE;
        end else if (!bus.waitrequest) begin
          capture  = 1'b1;
          fsm_next = HOLD;
        end
      end
      default: begin
        fsm_next = IDLE;
      end
    endcase
  end

  // On the zero-wait path the context is being latched in the same cycle,
  // so the live inputs are used; otherwise the latched copies.
  assign fmt_op   = latch ? opcode          : op_reg;
  assign fmt_k    = latch ? bus.eff_addr_lo : k_reg;
  assign fmt_r    = latch ? bus.rt_old      : rt_old_reg;
  assign fmt_rt   = latch ? rt              : rt_reg;
  assign fmt_data = form_result(fmt_op, fmt_k, fmt_r, bus.readdata);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_reg         <= '0;
      rt_reg         <= '0;
      k_reg          <= '0;
      rt_old_reg     <= '0;
      wb_reg_reg     <= '0;
      wb_data_reg    <= '0;
      misaligned_reg <= 1'b0;
    end else begin
      if (latch) begin
        op_reg         <= opcode;
        rt_reg         <= rt;
        k_reg          <= bus.eff_addr_lo;
        rt_old_reg     <= bus.rt_old;
        misaligned_reg <= set_mis;
      end
      // The result is formed once, when the word arrives, so wb_data never
      // depends combinationally on readdata and holds between writes.
      if (capture) begin
        wb_data_reg <= fmt_data;
        wb_reg_reg  <= fmt_rt;
      end
    end
  end

  // Gated with reset so both strobes drop the moment reset rises.
  assign bus.stall      = stall_int && !reset;
  assign bus.wb_valid   = wb_fire && !reset;
  assign bus.wb_reg     = wb_reg_reg;
  assign bus.wb_data    = wb_data_reg;
  assign bus.misaligned = misaligned_reg;

endmodule

// File: tb/tb_load_writeback_unit.sv
// Directed, table-driven bench for load_writeback_unit.
module tb_load_writeback_unit;

  localparam logic [2:0] ST_FETCH = 3'b000;
  localparam logic [2:0] ST_MEM   = 3'b011;
  localparam logic [2:0] ST_WB    = 3'b100;

  localparam logic [5:0] LB  = 6'b100000;
  localparam logic [5:0] LH  = 6'b100001;
  localparam logic [5:0] LWL = 6'b100010;
  localparam logic [5:0] LW  = 6'b100011;
  localparam logic [5:0] LBU = 6'b100100;
  localparam logic [5:0] LHU = 6'b100101;
  localparam logic [5:0] LWR = 6'b100110;

  typedef struct {
    string       name;
    logic [5:0]  op;
    logic [1:0]  k;
    logic [4:0]  rt;
    logic [31:0] rt_old;
    logic [31:0] rdata;
    int          waits;
    logic        exp_valid;
    logic        exp_mis;
    logic [4:0]  exp_reg;
    logic [31:0] exp_data;
  } vec_t;

  localparam int NVEC = 15;

  logic clk;
  logic reset;
  int   compared;
  int   mismatched;
  vec_t vecs [NVEC];

  load_writeback_unit_if bus ();

  load_writeback_unit #(
    .DATA_W    (32),
    .STATE_MEM (ST_MEM),
    .STATE_WB  (ST_WB)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.state       = ST_FETCH;
    bus.instr       = 32'd0;
    bus.eff_addr_lo = 2'd0;
    bus.mem_read    = 1'b0;
    bus.waitrequest = 1'b0;
    bus.readdata    = 32'd0;
    bus.rt_old      = 32'd0;
  endtask

  // MEMORY_ACCESS for waits+1 cycles (one cycle for a misaligned load),
  // then one WRITE_BACK cycle, then one FETCH cycle.
  task automatic run_vec(input vec_t v);
    int stalls;
    int cycles;
    stalls = 0;
    cycles = v.exp_mis ? 1 : v.waits + 1;
    for (int c = 0; c < cycles; c++) begin
      @(posedge clk); #1;
      bus.state       = ST_MEM;
      bus.instr       = {v.op, 5'd0, v.rt, 16'h0000};
      bus.eff_addr_lo = v.k;
      bus.rt_old      = v.rt_old;
      bus.mem_read    = 1'b1;
      bus.waitrequest = (c < v.waits);
      bus.readdata    = (c < v.waits) ? 32'h5A5A_5A5A : v.rdata;
      @(negedge clk);
      if (bus.stall) stalls++;
    end
    check({v.name, " stall_cycles"}, stalls, v.exp_mis ? 0 : v.waits);
    @(posedge clk); #1;
    bus.state       = ST_WB;
    bus.mem_read    = 1'b0;
    bus.waitrequest = 1'b0;
    bus.readdata    = 32'h0BAD_0BAD;
    @(negedge clk);
    check({v.name, " wb_valid"},   {31'd0, bus.wb_valid},   {31'd0, v.exp_valid});
    check({v.name, " wb_reg"},     {27'd0, bus.wb_reg},     {27'd0, v.exp_reg});
    check({v.name, " wb_data"},    bus.wb_data,             v.exp_data);
    check({v.name, " misaligned"}, {31'd0, bus.misaligned}, {31'd0, v.exp_mis});
    @(posedge clk); #1;
    bus.state = ST_FETCH;
    @(negedge clk);
    check({v.name, " wb_valid_drop"}, {31'd0, bus.wb_valid}, 32'd0);
    check({v.name, " wb_data_hold"},  bus.wb_data,           v.exp_data);
    $display("load %-10s op=%b k=%0d rt=%0d waits=%0d stalls=%0d wb_data=0x%08h mis=%b",
             v.name, v.op, v.k, v.rt, v.waits, stalls, bus.wb_data, bus.misaligned);
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;

    //          name          op   k     rt     rt_old         rdata          w  val  mis  reg    data
    vecs[0]  = '{"lb_k3",     LB,  2'd3, 5'd5,  32'h0,         32'h80FF_1234, 0, 1'b1, 1'b0, 5'd5,  32'hFFFF_FF80};
    vecs[1]  = '{"lhu_k2",    LHU, 2'd2, 5'd6,  32'h0,         32'h80FF_1234, 0, 1'b1, 1'b0, 5'd6,  32'h0000_80FF};
    vecs[2]  = '{"lh_k2",     LH,  2'd2, 5'd7,  32'h0,         32'h80FF_1234, 0, 1'b1, 1'b0, 5'd7,  32'hFFFF_80FF};
    vecs[3]  = '{"lwl_k1",    LWL, 2'd1, 5'd8,  32'hAABB_CCDD, 32'h1122_3344, 0, 1'b1, 1'b0, 5'd8,  32'h3344_CCDD};
    vecs[4]  = '{"lwr_k2",    LWR, 2'd2, 5'd9,  32'hAABB_CCDD, 32'h1122_3344, 0, 1'b1, 1'b0, 5'd9,  32'hAABB_1122};
    vecs[5]  = '{"lw_wait3",  LW,  2'd0, 5'd10, 32'h0,         32'hDEAD_BEEF, 3, 1'b1, 1'b0, 5'd10, 32'hDEAD_BEEF};
    vecs[6]  = '{"lw_mis",    LW,  2'd2, 5'd11, 32'h0,         32'h1111_1111, 1, 1'b0, 1'b1, 5'd10, 32'hDEAD_BEEF};
    vecs[7]  = '{"lbu_k1",    LBU, 2'd1, 5'd12, 32'h0,         32'h80FF_1234, 1, 1'b1, 1'b0, 5'd12, 32'h0000_0012};
    vecs[8]  = '{"lh_mis",    LH,  2'd1, 5'd13, 32'h0,         32'h2222_2222, 1, 1'b0, 1'b1, 5'd12, 32'h0000_0012};
    vecs[9]  = '{"lwl_k3",    LWL, 2'd3, 5'd14, 32'hAABB_CCDD, 32'h1122_3344, 2, 1'b1, 1'b0, 5'd14, 32'h1122_3344};
    vecs[10] = '{"lwr_k0",    LWR, 2'd0, 5'd15, 32'hAABB_CCDD, 32'hCAFE_F00D, 0, 1'b1, 1'b0, 5'd15, 32'hCAFE_F00D};
    vecs[11] = '{"lb_pos",    LB,  2'd0, 5'd16, 32'h0,         32'h0000_007F, 0, 1'b1, 1'b0, 5'd16, 32'h0000_007F};
    vecs[12] = '{"lwr_k3",    LWR, 2'd3, 5'd17, 32'hAABB_CCDD, 32'h1122_3344, 1, 1'b1, 1'b0, 5'd17, 32'hAABB_CC11};
    vecs[13] = '{"lwl_k0",    LWL, 2'd0, 5'd18, 32'hAABB_CCDD, 32'h1122_3344, 0, 1'b1, 1'b0, 5'd18, 32'h44BB_CCDD};
    vecs[14] = '{"lb_r0",     LB,  2'd2, 5'd0,  32'h0,         32'h80FF_1234, 0, 1'b1, 1'b0, 5'd0,  32'hFFFF_FFFF};

    // Reset state
    reset = 1'b1;
    idle_inputs();
    @(negedge clk);
    check("reset stall",      {31'd0, bus.stall},      32'd0);
    check("reset wb_valid",   {31'd0, bus.wb_valid},   32'd0);
    check("reset wb_reg",     {27'd0, bus.wb_reg},     32'd0);
    check("reset wb_data",    bus.wb_data,             32'd0);
    check("reset misaligned", {31'd0, bus.misaligned}, 32'd0);
    $display("reset: stall=%b wb_valid=%b wb_data=0x%08h", bus.stall, bus.wb_valid, bus.wb_data);
    reset = 1'b0;

    for (int i = 0; i < NVEC; i++) begin
      run_vec(vecs[i]);
    end

    // Reset pulsed while waiting on memory
    @(posedge clk); #1;
    bus.state       = ST_MEM;
    bus.instr       = {LW, 5'd0, 5'd20, 16'h0000};
    bus.eff_addr_lo = 2'd0;
    bus.mem_read    = 1'b1;
    bus.waitrequest = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_wait stall_before", {31'd0, bus.stall}, 32'd1);
    #1 reset = 1'b1;
    #1;
    check("rst_wait stall_async", {31'd0, bus.stall}, 32'd0);
    idle_inputs();
    @(posedge clk); #1;
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    bus.state    = ST_WB;
    bus.readdata = 32'hDEAD_BEEF;
    @(negedge clk);
    check("rst_wait wb_valid",   {31'd0, bus.wb_valid},   32'd0);
    check("rst_wait wb_data",    bus.wb_data,             32'd0);
    check("rst_wait wb_reg",     {27'd0, bus.wb_reg},     32'd0);
    check("rst_wait misaligned", {31'd0, bus.misaligned}, 32'd0);
    $display("reset during WAIT_MEM: wb_valid=%b wb_data=0x%08h", bus.wb_valid, bus.wb_data);

    // Controller leaves MEMORY_ACCESS while the unit is waiting
    @(posedge clk); #1;
    idle_inputs();
    bus.state       = ST_MEM;
    bus.instr       = {LW, 5'd0, 5'd21, 16'h0000};
    bus.mem_read    = 1'b1;
    bus.waitrequest = 1'b1;
    @(posedge clk); #1;
    bus.state       = ST_FETCH;
    bus.mem_read    = 1'b0;
    bus.waitrequest = 1'b0;
    bus.readdata    = 32'h1234_5678;
    @(negedge clk);
    check("abort stall", {31'd0, bus.stall}, 32'd0);
    @(posedge clk); #1;
    bus.state = ST_WB;
    @(negedge clk);
    check("abort wb_valid", {31'd0, bus.wb_valid}, 32'd0);
    check("abort wb_data",  bus.wb_data,           32'd0);
    $display("abort in WAIT_MEM: wb_valid=%b wb_data=0x%08h", bus.wb_valid, bus.wb_data);

    // Non-load (ADDU) through MEMORY_ACCESS and WRITE_BACK
    @(posedge clk); #1;
    idle_inputs();
    bus.state       = ST_MEM;
    bus.instr       = {6'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'h21};
    bus.mem_read    = 1'b1;
    bus.waitrequest = 1'b1;
    @(negedge clk);
    check("addu stall", {31'd0, bus.stall}, 32'd0);
    @(posedge clk); #1;
    bus.state       = ST_WB;
    bus.mem_read    = 1'b0;
    bus.waitrequest = 1'b0;
    @(negedge clk);
    check("addu wb_valid", {31'd0, bus.wb_valid}, 32'd0);
    $display("addu: stall=0 expected, wb_valid=%b", bus.wb_valid);
    @(posedge clk); #1;
    idle_inputs();

    // Unit recovers for a normal load afterwards
    run_vec('{"lw_after", LW, 2'd0, 5'd22, 32'h0, 32'h0F1E_2D3C, 2, 1'b1, 1'b0, 5'd22, 32'h0F1E_2D3C});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
